// File: rtl/addr_seq.sv
// ---------------------------------------------------------------------------
// addr_seq
// Self-timed SRAM read-address sequencer for the systolic array queues.
// A start pulse launches an internal counter that walks every weight/data
// queue through its tile, each queue starting SKEW cycles after the previous
// one. All outputs are registered; stall freezes the sequence in RUN.
//
// Ports
//   clk                 in   clock, rising edge
//   rst                 in   asynchronous active-high reset
//   start               in   begin a sequence (sampled only in IDLE)
//   tile_len            in   addresses per queue (sampled with start)
//   base_w              in   weight base address (sampled with start)
//   base_d              in   data base address (sampled with start)
//   stall               in   hold counter, outputs and state while in RUN
//   busy                out  state is not IDLE
//   done                out  one-cycle pulse when the sequence completes
//   raddr_valid_packed  out  bit k = queue k address valid
//   sram_raddr_w_packed out  queue k weight address at [(k+1)*AW-1 -: AW]
//   sram_raddr_d_packed out  queue k data address, same packing
// ---------------------------------------------------------------------------
module addr_seq #(
    parameter int unsigned ARRAY_SIZE  = 8,
    parameter int unsigned QUEUE_SIZE  = 4,
    parameter int unsigned QUEUE_COUNT = (ARRAY_SIZE + QUEUE_SIZE - 1) / QUEUE_SIZE,
    parameter int unsigned SKEW        = QUEUE_SIZE,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned CNT_WIDTH   = 7,
    parameter int unsigned IDLE_ADDR   = 127
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CNT_WIDTH-1:0]              tile_len,
    input  logic [ADDR_WIDTH-1:0]             base_w,
    input  logic [ADDR_WIDTH-1:0]             base_d,
    input  logic                              stall,
    output logic                              busy,
    output logic                              done,
    output logic [QUEUE_COUNT-1:0]            raddr_valid_packed,
    output logic [QUEUE_COUNT*ADDR_WIDTH-1:0] sram_raddr_w_packed,
    output logic [QUEUE_COUNT*ADDR_WIDTH-1:0] sram_raddr_d_packed
);

    localparam int unsigned CW = CNT_WIDTH + 1;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned QC = QUEUE_COUNT;

    // Extra cycles the last queue trails queue 0.
    localparam logic [CW-1:0] SPAN   = CW'((QC - 1) * SKEW);
    localparam logic [AW-1:0] IDLE_A = AW'(IDLE_ADDR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [CW-1:0]        last;
    logic                 load_cfg;
    logic                 load_out;

    logic [CNT_WIDTH-1:0] len_q;
    logic [AW-1:0]        bw_q;
    logic [AW-1:0]        bd_q;

    logic [QC-1:0]        valid_calc;
    logic [QC*AW-1:0]     w_calc;
    logic [QC*AW-1:0]     d_calc;
    logic [CW-1:0]        lo;
    logic [CW-1:0]        off;

    // Final counter value: last queue issues its last address here.
    assign last = CW'(len_q) - CW'(1) + SPAN;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_cfg  = 1'b0;
        load_out  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (tile_len != '0) begin
                        state_nxt = S_RUN;
                        load_cfg  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        // Empty tile: report completion without issuing anything.
                        state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (!stall) begin
                    load_out = 1'b1;
                    if (cnt == last) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-queue address generation from the shared counter.
    always_comb begin
        valid_calc = '0;
        w_calc     = {QC{IDLE_A}};
        d_calc     = {QC{IDLE_A}};
        lo         = '0;
        off        = '0;
        for (int k = 0; k < int'(QC); k++) begin
            lo  = CW'(k * int'(SKEW));
            off = cnt - lo;
            // Queue k is active for cnt in [k*SKEW, k*SKEW + len - 1].
            if ((cnt >= lo) && (off < CW'(len_q))) begin
                valid_calc[k]        = 1'b1;
                w_calc[k*AW +: AW]   = bw_q + AW'(off);
                d_calc[k*AW +: AW]   = bd_q + AW'(off);
            end
        end
    end

    // Sequence configuration captured with start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            bw_q  <= '0;
            bd_q  <= '0;
        end else if (load_cfg) begin
            len_q <= tile_len;
            bw_q  <= base_w;
            bd_q  <= base_d;
        end
    end

    // Status flags track the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
        end
    end

    // Address/valid registers: idle outside RUN, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_valid_packed  <= '0;
            sram_raddr_w_packed <= {QC{IDLE_A}};
            sram_raddr_d_packed <= {QC{IDLE_A}};
        end else if (state != S_RUN) begin
            raddr_valid_packed  <= '0;
            sram_raddr_w_packed <= {QC{IDLE_A}};
            sram_raddr_d_packed <= {QC{IDLE_A}};
        end else if (load_out) begin
            raddr_valid_packed  <= valid_calc;
            sram_raddr_w_packed <= w_calc;
            sram_raddr_d_packed <= d_calc;
        end
    end

endmodule

// File: tb/tb_addr_seq.sv
// ---------------------------------------------------------------------------
// tb_addr_seq
// Directed bench for addr_seq: a behavioural model pushes the expected output
// snapshot for every clock edge into a scoreboard, which is popped and
// compared one step after the edge. Directed checks cover timing, counts and
// address sequences for each scenario.
// ---------------------------------------------------------------------------
module tb_addr_seq;

    localparam int QC = 2;
    localparam int SK = 4;
    localparam int AW = 10;
    localparam int CW = 7;
    localparam int IA = 127;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           stall;
    logic [CW-1:0]  tile_len;
    logic [AW-1:0]  base_w;
    logic [AW-1:0]  base_d;
    logic           busy;
    logic           done;
    logic [QC-1:0]  valid;
    logic [QC*AW-1:0] w_bus;
    logic [QC*AW-1:0] d_bus;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic [QC-1:0]    valid;
        logic [QC*AW-1:0] w;
        logic [QC*AW-1:0] d;
    } snap_t;

    snap_t sb[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    // Behavioural model state
    int    m_state;
    int    m_cnt;
    int    m_len;
    int    m_bw;
    int    m_bd;
    snap_t m_out;

    // Per-run observations
    int    done_edge;
    int    busy_cnt;
    int    vc[QC];
    int    fv[QC];
    int    w0_seq[$];
    bit    seen_done;

    addr_seq #(
        .ARRAY_SIZE (8),
        .QUEUE_SIZE (4),
        .SKEW       (SK),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW),
        .IDLE_ADDR  (IA)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .tile_len            (tile_len),
        .base_w              (base_w),
        .base_d              (base_d),
        .stall               (stall),
        .busy                (busy),
        .done                (done),
        .raddr_valid_packed  (valid),
        .sram_raddr_w_packed (w_bus),
        .sram_raddr_d_packed (d_bus)
    );

    always #5 clk = ~clk;

    function automatic snap_t idle_snap();
        snap_t s;
        s.busy  = 1'b0;
        s.done  = 1'b0;
        s.valid = '0;
        for (int k = 0; k < QC; k++) begin
            s.w[k*AW +: AW] = AW'(IA);
            s.d[k*AW +: AW] = AW'(IA);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        snap_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ".busy"},  32'(busy),  32'(e.busy));
            check({tag, ".done"},  32'(done),  32'(e.done));
            check({tag, ".valid"}, 32'(valid), 32'(e.valid));
            check({tag, ".w"},     32'(w_bus), 32'(e.w));
            check({tag, ".d"},     32'(d_bus), 32'(e.d));
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_len   = 0;
        m_bw    = 0;
        m_bd    = 0;
        m_out   = idle_snap();
    endtask

    // One clock edge of the reference behaviour (0=IDLE, 1=RUN, 2=DONE).
    task automatic model_edge(input bit st, input int tl, input int bw, input int bd, input bit sl);
        int ns;
        int lo;
        snap_t o;
        o = m_out;
        if (m_state == 1) begin
            if (!sl) begin
                for (int k = 0; k < QC; k++) begin
                    lo = k * SK;
                    if (m_cnt >= lo && m_cnt <= lo + m_len - 1) begin
                        o.valid[k]      = 1'b1;
                        o.w[k*AW +: AW] = AW'((m_bw + m_cnt - lo) % 1024);
                        o.d[k*AW +: AW] = AW'((m_bd + m_cnt - lo) % 1024);
                    end else begin
                        o.valid[k]      = 1'b0;
                        o.w[k*AW +: AW] = AW'(IA);
                        o.d[k*AW +: AW] = AW'(IA);
                    end
                end
            end
        end else begin
            o = idle_snap();
        end
        ns = m_state;
        case (m_state)
            0: if (st) begin
                if (tl != 0) begin
                    m_len = tl;
                    m_bw  = bw;
                    m_bd  = bd;
                    m_cnt = 0;
                    ns    = 1;
                end else begin
                    ns = 2;
                end
            end
            1: if (!sl) begin
                if (m_cnt == m_len - 1 + (QC - 1) * SK) ns = 2;
                else m_cnt = m_cnt + 1;
            end
            default: ns = 0;
        endcase
        m_state = ns;
        o.busy  = (ns != 0);
        o.done  = (ns == 2);
        m_out   = o;
    endtask

    task automatic step(input bit st, input int tl, input int bw, input int bd, input bit sl,
                        input string tag);
        start    = st;
        tile_len = CW'(tl);
        base_w   = AW'(bw);
        base_d   = AW'(bd);
        stall    = sl;
        model_edge(st, tl, bw, bd, sl);
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic record(input int i);
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1 && !seen_done) begin
            seen_done = 1'b1;
            done_edge = i;
        end
        for (int k = 0; k < QC; k++) begin
            if (valid[k] === 1'b1) begin
                vc[k]++;
                if (fv[k] < 0) fv[k] = i;
            end
        end
        if (valid[0] === 1'b1) w0_seq.push_back(int'(w_bus[AW-1:0]));
    endtask

    // Reset asserted between edges; outputs must idle before the next edge.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        model_reset();
        sb.push_back(m_out);
        #2;
        compare_out({tag, ".async"});
        model_reset();
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        compare_out({tag, ".held"});
        rst = 1'b0;
    endtask

    // Edge 0 carries start; edge i processes counter value i-1 in RUN.
    task automatic run_seq(input string name, input int tl, input int bw, input int bd,
                           input int stall_at, input int stall_len,
                           input int restart_at, input int abort_at);
        bit sl;
        seen_done = 1'b0;
        done_edge = -1;
        busy_cnt  = 0;
        w0_seq.delete();
        for (int k = 0; k < QC; k++) begin
            vc[k] = 0;
            fv[k] = -1;
        end
        step(1'b1, tl, bw, bd, 1'b0, name);
        record(0);
        for (int i = 1; i < 400 && !seen_done; i++) begin
            if (i == abort_at) begin
                async_reset(name);
                return;
            end
            sl = (i >= stall_at) && (i < stall_at + stall_len);
            if (i == restart_at) step(1'b1, 3, 500, 600, sl, name);
            else                 step(1'b0, 0, 0, 0, sl, name);
            record(i);
        end
        check({name, ".done_seen"}, 32'(seen_done), 32'd1);
        // First IDLE cycle; stall has no effect in DONE.
        step(1'b0, 0, 0, 0, 1'b1, {name, ".to_idle"});
    endtask

    int wrap_exp[8] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        tile_len = '0;
        base_w   = '0;
        base_d   = '0;
        model_reset();
        sb.push_back(m_out);
        #2;
        compare_out("reset");
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        compare_out("reset_hold");
        rst = 1'b0;
        step(1'b0, 0, 0, 0, 1'b0, "idle");

        // Default tile: LAST=102, 103 RUN cycles + 1 DONE cycle.
        run_seq("base", 99, 0, 200, -1, 0, -1, -1);
        check("base.done_edge", 32'(done_edge), 32'd103);
        check("base.busy_cycles", 32'(busy_cnt), 32'd104);
        check("base.q0_count", 32'(vc[0]), 32'd99);
        check("base.q1_count", 32'(vc[1]), 32'd99);
        check("base.q0_first", 32'(fv[0]), 32'd1);
        check("base.q1_first", 32'(fv[1]), 32'd5);
        check("base.w0_first", 32'(w0_seq[0]), 32'd0);
        check("base.w0_last", 32'(w0_seq[98]), 32'd98);

        // Back-to-back start in the first IDLE cycle; 3-cycle stall at cnt=50.
        run_seq("stall", 99, 0, 200, 51, 3, -1, -1);
        check("stall.done_edge", 32'(done_edge), 32'd106);
        check("stall.q0_count", 32'(vc[0]), 32'd102);
        check("stall.q1_count", 32'(vc[1]), 32'd102);

        run_seq("wrap", 8, 1020, 5, -1, 0, -1, -1);
        check("wrap.len", 32'(w0_seq.size()), 32'd8);
        for (int j = 0; j < 8 && j < w0_seq.size(); j++)
            check($sformatf("wrap.w0[%0d]", j), 32'(w0_seq[j]), 32'(wrap_exp[j]));

        run_seq("len0", 0, 11, 22, -1, 0, -1, -1);
        check("len0.done_edge", 32'(done_edge), 32'd0);
        check("len0.busy_cycles", 32'(busy_cnt), 32'd1);
        check("len0.q0_count", 32'(vc[0]), 32'd0);
        check("len0.q1_count", 32'(vc[1]), 32'd0);

        run_seq("len1", 1, 30, 40, -1, 0, -1, -1);
        check("len1.done_edge", 32'(done_edge), 32'd5);
        check("len1.q0_count", 32'(vc[0]), 32'd1);
        check("len1.q1_count", 32'(vc[1]), 32'd1);
        check("len1.q0_first", 32'(fv[0]), 32'd1);
        check("len1.q1_first", 32'(fv[1]), 32'd5);

        run_seq("restart", 20, 100, 300, -1, 0, 10, -1);
        check("restart.done_edge", 32'(done_edge), 32'd24);
        check("restart.q0_count", 32'(vc[0]), 32'd20);

        // Stall on the edge that would enter DONE (cnt=LAST=5).
        run_seq("stall_last", 2, 0, 0, 6, 2, -1, -1);
        check("stall_last.done_edge", 32'(done_edge), 32'd8);

        // Abort at cnt=30, then a fresh sequence from cnt=0.
        run_seq("abort", 40, 10, 20, -1, 0, -1, 31);
        check("abort.no_done", 32'(seen_done), 32'd0);
        step(1'b0, 0, 0, 0, 1'b0, "abort.idle");
        run_seq("fresh", 5, 7, 9, -1, 0, -1, -1);
        check("fresh.q0_first", 32'(fv[0]), 32'd1);
        check("fresh.w0_first", 32'(w0_seq[0]), 32'd7);
        check("fresh.done_edge", 32'(done_edge), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
